// File: rtl/servo_cmd_sched_pkg.sv
// servo_cmd_sched_pkg
//   Shared constants for the servo command scheduler: default word size,
//   default clamp/failsafe widths, source-state and sequencer-state encodings.
package servo_cmd_sched_pkg;

  localparam int DEF_WORDSIZE       = 15;
  localparam int DEF_MIN_WIDTH      = 900;
  localparam int DEF_MAX_WIDTH      = 2100;
  localparam int DEF_FAILSAFE_WIDTH = 1500;
  localparam int DEF_TIMEOUT_US     = 100000;

  localparam int NUM_CH = 6;

  // src_state encodings
  localparam logic [1:0] SRC_HOST     = 2'd0;
  localparam logic [1:0] SRC_RC       = 2'd1;
  localparam logic [1:0] SRC_FAILSAFE = 2'd2;

  // sequencer state encodings
  localparam logic [1:0] SEQ_IDLE  = 2'd0;
  localparam logic [1:0] SEQ_CLAMP = 2'd1;
  localparam logic [1:0] SEQ_FLAG  = 2'd2;

endpackage

// File: rtl/servo_width_clamp.sv
// servo_width_clamp
//   Combinational clamp of one pulse-width word into [MIN_WIDTH, MAX_WIDTH].
//   Ports:
//     width_in  - raw width, us
//     width_out - clamped width, us
module servo_width_clamp
  import servo_cmd_sched_pkg::*;
#(
  parameter int WORDSIZE  = DEF_WORDSIZE,
  parameter int MIN_WIDTH = DEF_MIN_WIDTH,
  parameter int MAX_WIDTH = DEF_MAX_WIDTH
) (
  input  logic [WORDSIZE-1:0] width_in,
  output logic [WORDSIZE-1:0] width_out
);

  localparam logic [WORDSIZE-1:0] MIN_W = WORDSIZE'(MIN_WIDTH);
  localparam logic [WORDSIZE-1:0] MAX_W = WORDSIZE'(MAX_WIDTH);

  always_comb begin
    width_out = width_in;
    if (width_in < MIN_W)
      width_out = MIN_W;
    else if (width_in > MAX_W)
      width_out = MAX_W;
  end

endmodule

// File: rtl/servo_cmd_sched.sv
// servo_cmd_sched
//   Selects the servo command source (host, RC receiver, failsafe), and on
//   each publish event clamps the six channel widths one per cycle into
//   staging registers, then moves all six to the outputs on a single edge
//   together with a one-cycle data_update_flag.
//
//   Build option: define SERVO_RC_PASSTHRU_EN to enable the RC receiver
//   source. Without it, rc_frame_valid/rc_width are ignored and host loss
//   goes straight to failsafe.
//
//   Ports:
//     clk, rst_n                  - system clock, async active-low reset
//     pwm_clk                     - 1 MHz tick, one clk wide (timer base)
//     host_wr_valid/ch/data/ready - host shadow writes (ch 0..5), commit (ch 7)
//     rc_frame_valid, rc_width    - RC frame strobe and six widths (ch1 in LSBs)
//     pulse_width_ch1..ch6        - published widths
//     data_update_flag            - one-cycle pulse when all six widths update
//     src_state                   - 0 HOST, 1 RC, 2 FAILSAFE
//
//   Sequencer states:
//     state     | meaning
//     ----------+-----------------------------------------------------------
//     SEQ_IDLE  | waiting for a publish trigger; host writes accepted
//     SEQ_CLAMP | clamp frame[seq_idx] into stage[seq_idx], idx 0..5
//     SEQ_FLAG  | copy stage to outputs, pulse data_update_flag
module servo_cmd_sched
  import servo_cmd_sched_pkg::*;
#(
  parameter int WORDSIZE       = DEF_WORDSIZE,
  parameter int MIN_WIDTH      = DEF_MIN_WIDTH,
  parameter int MAX_WIDTH      = DEF_MAX_WIDTH,
  parameter int FAILSAFE_WIDTH = DEF_FAILSAFE_WIDTH,
  parameter int TIMEOUT_US     = DEF_TIMEOUT_US
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pwm_clk,
  input  logic                    host_wr_valid,
  input  logic [2:0]              host_wr_ch,
  input  logic [WORDSIZE-1:0]     host_wr_data,
  output logic                    host_wr_ready,
  input  logic                    rc_frame_valid,
  input  logic [6*WORDSIZE-1:0]   rc_width,
  output logic [WORDSIZE-1:0]     pulse_width_ch1,
  output logic [WORDSIZE-1:0]     pulse_width_ch2,
  output logic [WORDSIZE-1:0]     pulse_width_ch3,
  output logic [WORDSIZE-1:0]     pulse_width_ch4,
  output logic [WORDSIZE-1:0]     pulse_width_ch5,
  output logic [WORDSIZE-1:0]     pulse_width_ch6,
  output logic                    data_update_flag,
  output logic [1:0]              src_state
);

  localparam int                  TW    = $clog2(TIMEOUT_US + 1);
  localparam logic [TW-1:0]       T_MAX = TW'(TIMEOUT_US);
  localparam logic [WORDSIZE-1:0] FS_W  = WORDSIZE'(FAILSAFE_WIDTH);

  logic [TW-1:0]       host_tmr, rc_tmr;
  logic                host_alive, rc_alive;
  logic [1:0]          src_q;
  logic [1:0]          seq_state;
  logic [2:0]          seq_idx;
  logic [WORDSIZE-1:0] shadow [NUM_CH];
  logic [WORDSIZE-1:0] frame  [NUM_CH];
  logic [WORDSIZE-1:0] stage  [NUM_CH];
  logic [WORDSIZE-1:0] rc_buf [NUM_CH];
  logic                rc_pend, fs_pend;
  logic                idle, wr_acc, commit_acc, fs_entry, rc_strobe;
  logic                go_host, go_rc_live, go_rc_pend, go_fs, launch;
  logic [WORDSIZE-1:0] clamp_in, clamp_out;

`ifdef SERVO_RC_PASSTHRU_EN
  assign rc_strobe = rc_frame_valid;
  assign rc_alive  = (rc_tmr < T_MAX);
`else
  logic unused_rc;
  assign rc_strobe = 1'b0;
  assign rc_alive  = 1'b0;
  assign unused_rc = rc_frame_valid;
`endif

  assign host_alive = (host_tmr < T_MAX);

  always_comb begin
    if (host_alive)    src_state = SRC_HOST;
    else if (rc_alive) src_state = SRC_RC;
    else               src_state = SRC_FAILSAFE;
  end

  assign fs_entry = (src_state == SRC_FAILSAFE) && (src_q != SRC_FAILSAFE);
  assign idle     = (seq_state == SEQ_IDLE);

  // Ready also drops during the flag cycle so a new commit cannot start a
  // pass on the same edge the previous one is being published.
  assign host_wr_ready = idle && !rc_pend && !fs_pend && !data_update_flag;
  assign wr_acc        = host_wr_valid && host_wr_ready;
  assign commit_acc    = wr_acc && (host_wr_ch == 3'd7);

  // Trigger priority in IDLE: host commit, newest live RC frame, buffered
  // RC frame, failsafe. A commit on the same edge as an RC frame wins.
  assign go_host    = commit_acc;
  assign go_rc_live = idle && !go_host && rc_strobe && !host_alive;
  assign go_rc_pend = idle && !go_host && !go_rc_live && rc_pend && !host_alive;
  assign go_fs      = idle && !go_host && !go_rc_live && !go_rc_pend &&
                      (fs_pend || fs_entry);
  assign launch     = go_host || go_rc_live || go_rc_pend || go_fs;

  // source timers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_tmr <= T_MAX;
      rc_tmr   <= T_MAX;
      src_q    <= SRC_FAILSAFE;
    end else begin
      src_q <= src_state;
      if (commit_acc)
        host_tmr <= '0;
      else if (pwm_clk && host_alive)
        host_tmr <= host_tmr + TW'(1);
      if (rc_strobe)
        rc_tmr <= '0;
      else if (pwm_clk && (rc_tmr < T_MAX))
        rc_tmr <= rc_tmr + TW'(1);
    end
  end

  // shadows, pending RC frame, pending failsafe, frame snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_pend <= 1'b0;
      fs_pend <= 1'b1;   // forces a failsafe publish right after reset
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= FS_W;
        frame[i]  <= FS_W;
        rc_buf[i] <= FS_W;
      end
    end else begin
      if (!idle && rc_strobe)
        rc_pend <= 1'b1;
      else if (idle)
        rc_pend <= 1'b0;   // launched, superseded, or stale (host alive)

      if (launch)
        fs_pend <= 1'b0;
      else if (fs_entry)
        fs_pend <= 1'b1;

      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_acc && (host_wr_ch == 3'(i)))
          shadow[i] <= host_wr_data;
        if (!idle && rc_strobe)
          rc_buf[i] <= rc_width[i*WORDSIZE +: WORDSIZE];
        if (go_host)
          frame[i] <= shadow[i];
        else if (go_rc_live)
          frame[i] <= rc_width[i*WORDSIZE +: WORDSIZE];
        else if (go_rc_pend)
          frame[i] <= rc_buf[i];
        else if (go_fs)
          frame[i] <= FS_W;
      end
    end
  end

  assign clamp_in = frame[seq_idx];

  servo_width_clamp #(
    .WORDSIZE  (WORDSIZE),
    .MIN_WIDTH (MIN_WIDTH),
    .MAX_WIDTH (MAX_WIDTH)
  ) u_clamp (
    .width_in  (clamp_in),
    .width_out (clamp_out)
  );

  // sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_state        <= SEQ_IDLE;
      seq_idx          <= 3'd0;
      data_update_flag <= 1'b0;
      pulse_width_ch1  <= FS_W;
      pulse_width_ch2  <= FS_W;
      pulse_width_ch3  <= FS_W;
      pulse_width_ch4  <= FS_W;
      pulse_width_ch5  <= FS_W;
      pulse_width_ch6  <= FS_W;
      for (int i = 0; i < NUM_CH; i++)
        stage[i] <= FS_W;
    end else begin
      data_update_flag <= 1'b0;
      case (seq_state)
        SEQ_IDLE: begin
          if (launch) begin
            seq_state <= SEQ_CLAMP;
            seq_idx   <= 3'd0;
          end
        end
        SEQ_CLAMP: begin
          stage[seq_idx] <= clamp_out;
          if (seq_idx == 3'd5)
            seq_state <= SEQ_FLAG;
          else
            seq_idx <= seq_idx + 3'd1;
        end
        SEQ_FLAG: begin
          pulse_width_ch1  <= stage[0];
          pulse_width_ch2  <= stage[1];
          pulse_width_ch3  <= stage[2];
          pulse_width_ch4  <= stage[3];
          pulse_width_ch5  <= stage[4];
          pulse_width_ch6  <= stage[5];
          data_update_flag <= 1'b1;
          seq_state        <= SEQ_IDLE;
        end
        default: seq_state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_cmd_sched.sv
// tb_servo_cmd_sched
//   Directed bench for servo_cmd_sched with a short source timeout (6 ticks)
//   so that source-loss scenarios fit in a few hundred cycles. The RC
//   scenarios are selected by SERVO_RC_PASSTHRU_EN, matching the DUT build.
module tb_servo_cmd_sched;

  localparam int W  = 15;
  localparam int TO = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            pwm_clk;
  logic            host_wr_valid;
  logic [2:0]      host_wr_ch;
  logic [W-1:0]    host_wr_data;
  logic            host_wr_ready;
  logic            rc_frame_valid;
  logic [6*W-1:0]  rc_width;
  logic [W-1:0]    pulse_width_ch1, pulse_width_ch2, pulse_width_ch3;
  logic [W-1:0]    pulse_width_ch4, pulse_width_ch5, pulse_width_ch6;
  logic            data_update_flag;
  logic [1:0]      src_state;

  int n_checks = 0;
  int n_fail   = 0;
  int flag_cnt = 0;
  int f0;

  servo_cmd_sched #(
    .WORDSIZE       (W),
    .MIN_WIDTH      (900),
    .MAX_WIDTH      (2100),
    .FAILSAFE_WIDTH (1500),
    .TIMEOUT_US     (TO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pwm_clk          (pwm_clk),
    .host_wr_valid    (host_wr_valid),
    .host_wr_ch       (host_wr_ch),
    .host_wr_data     (host_wr_data),
    .host_wr_ready    (host_wr_ready),
    .rc_frame_valid   (rc_frame_valid),
    .rc_width         (rc_width),
    .pulse_width_ch1  (pulse_width_ch1),
    .pulse_width_ch2  (pulse_width_ch2),
    .pulse_width_ch3  (pulse_width_ch3),
    .pulse_width_ch4  (pulse_width_ch4),
    .pulse_width_ch5  (pulse_width_ch5),
    .pulse_width_ch6  (pulse_width_ch6),
    .data_update_flag (data_update_flag),
    .src_state        (src_state)
  );

  always #5 clk = ~clk;

  // Count publish pulses shortly after each active edge.
  always @(posedge clk) begin
    #2;
    if (data_update_flag) flag_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_widths(input string tag, input int e1, input int e2, input int e3,
                            input int e4, input int e5, input int e6);
    chk({tag, "_ch1"}, pulse_width_ch1, e1);
    chk({tag, "_ch2"}, pulse_width_ch2, e2);
    chk({tag, "_ch3"}, pulse_width_ch3, e3);
    chk({tag, "_ch4"}, pulse_width_ch4, e4);
    chk({tag, "_ch5"}, pulse_width_ch5, e5);
    chk({tag, "_ch6"}, pulse_width_ch6, e6);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!host_wr_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", host_wr_ready, 1);
  endtask

  task automatic host_write(input logic [2:0] ch, input int data);
    wait_ready();
    host_wr_valid = 1'b1;
    host_wr_ch    = ch;
    host_wr_data  = W'(data);
    @(negedge clk);
    host_wr_valid = 1'b0;
  endtask

  // Called one negedge after the trigger edge. Flag must appear exactly
  // after the 8th edge counted from the trigger (7 edges later), outputs
  // must hold their old value until then, and ready must be low 8 cycles.
  task automatic after_trigger(input string tag, input int old_ch1);
    int rl = 0;
    for (int s = 1; s <= 9; s++) begin
      if (s > 1) @(negedge clk);
      if (!host_wr_ready) rl++;
      if (s == 7) begin
        chk({tag, "_flag_early"}, data_update_flag, 0);
        chk({tag, "_hold_ch1"}, pulse_width_ch1, old_ch1);
      end
      if (s == 8) chk({tag, "_flag"}, data_update_flag, 1);
      if (s == 9) chk({tag, "_flag_one_cycle"}, data_update_flag, 0);
    end
    chk({tag, "_ready_low"}, rl, 8);
  endtask

  task automatic commit_check(input string tag, input int old_ch1);
    wait_ready();
    f0 = flag_cnt;
    host_wr_valid = 1'b1;
    host_wr_ch    = 3'd7;
    @(negedge clk);
    host_wr_valid = 1'b0;
    chk({tag, "_src"}, src_state, 0);
    after_trigger(tag, old_ch1);
    chk({tag, "_nflag"}, flag_cnt - f0, 1);
  endtask

  initial begin
    rst_n          = 1'b0;
    pwm_clk        = 1'b0;
    host_wr_valid  = 1'b0;
    host_wr_ch     = 3'd0;
    host_wr_data   = '0;
    rc_frame_valid = 1'b0;
    rc_width       = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_src", src_state, 2);
    chk("rst_ready", host_wr_ready, 0);
    chk("rst_flag", data_update_flag, 0);
    chk_widths("rst", 1500, 1500, 1500, 1500, 1500, 1500);

    // boot failsafe publish
    f0 = flag_cnt;
    rst_n = 1'b1;
    @(negedge clk);
    after_trigger("boot", 1500);
    chk("boot_nflag", flag_cnt - f0, 1);
    chk("boot_src", src_state, 2);
    chk_widths("boot", 1500, 1500, 1500, 1500, 1500, 1500);

    // host writes with clamping, uncommitted writes invisible
    host_write(3'd0, 500);
    host_write(3'd1, 2500);
    host_write(3'd2, 1200);
    host_write(3'd3, 1200);
    host_write(3'd4, 1200);
    host_write(3'd5, 1200);
    host_write(3'd6, 100);
    repeat (3) @(negedge clk);
    chk_widths("uncommitted", 1500, 1500, 1500, 1500, 1500, 1500);
    chk("uncommitted_flags", flag_cnt - f0, 1);
    commit_check("commit1", 1500);
    chk_widths("commit1", 900, 2100, 1200, 1200, 1200, 1200);

    // shadows persist across commits
    host_write(3'd0, 1000);
    commit_check("persist", 900);
    chk_widths("persist", 1000, 2100, 1200, 1200, 1200, 1200);

    // clamp boundaries
    host_write(3'd0, 900);
    host_write(3'd1, 2100);
    host_write(3'd2, 899);
    host_write(3'd3, 2101);
    host_write(3'd4, 0);
    host_write(3'd5, 32767);
    commit_check("bounds", 1000);
    chk_widths("bounds", 900, 2100, 900, 2100, 900, 2100);

    // reset in the middle of a clamp pass
    wait_ready();
    host_wr_valid = 1'b1;
    host_wr_ch    = 3'd7;
    @(negedge clk);
    host_wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    f0 = flag_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_flag", data_update_flag, 0);
    chk("midrst_ready", host_wr_ready, 0);
    chk("midrst_src", src_state, 2);
    chk_widths("midrst", 1500, 1500, 1500, 1500, 1500, 1500);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    after_trigger("post_rst", 1500);
    chk("post_rst_nflag", flag_cnt - f0, 1);

    // shadows were reset to failsafe
    host_write(3'd0, 1000);
    commit_check("after_rst", 1500);
    chk_widths("after_rst", 1000, 1500, 1500, 1500, 1500, 1500);

    // host loss with RC frames arriving (tick every other cycle)
    f0 = flag_cnt;
    rc_width = {15'd1600, 15'd1600, 15'd1600, 15'd1600, 15'd1600, 15'd1600};
    for (int s = 1; s <= 50; s++) begin
      pwm_clk        = (s % 2 == 1) && (s <= 37);
      rc_frame_valid = (s == 4) || (s == 10) || (s == 19) || (s == 28) || (s == 37);
      @(negedge clk);
      if (s == 10) chk("loss_src_alive", src_state, 0);
`ifdef SERVO_RC_PASSTHRU_EN
      if (s == 11) chk("loss_src_rc", src_state, 1);
      if (s == 26 || s == 35 || s == 44) chk("rc_frame_flag", data_update_flag, 1);
`else
      if (s == 11) chk("loss_src_fs", src_state, 2);
      if (s == 19) chk("fs_flag", data_update_flag, 1);
`endif
    end
    pwm_clk        = 1'b0;
    rc_frame_valid = 1'b0;
`ifdef SERVO_RC_PASSTHRU_EN
    chk("rc_nflag", flag_cnt - f0, 3);
    chk("rc_src_end", src_state, 1);
    chk_widths("rc", 1600, 1600, 1600, 1600, 1600, 1600);

    // frame A during a host pass, frame B before IDLE, host times out
    wait_ready();
    f0 = flag_cnt;
    for (int s = 1; s <= 30; s++) begin
      host_wr_valid  = (s == 1);
      host_wr_ch     = 3'd7;
      pwm_clk        = (s >= 2) && (s <= 7);
      rc_frame_valid = (s == 3) || (s == 6);
      if (s == 3) rc_width = {15'd2000, 15'd2000, 15'd2000, 15'd2000, 15'd2000, 15'd2000};
      if (s == 6) rc_width = {15'd1700, 15'd1600, 15'd1400, 15'd1300, 15'd1200, 15'd1100};
      @(negedge clk);
      if (s == 7) chk("ab_src_rc", src_state, 1);
      if (s == 8) begin
        chk("ab_host_flag", data_update_flag, 1);
        chk("ab_host_ch1", pulse_width_ch1, 1000);
        chk("ab_host_ch2", pulse_width_ch2, 1500);
      end
      if (s == 16) chk("ab_b_flag", data_update_flag, 1);
    end
    host_wr_valid  = 1'b0;
    pwm_clk        = 1'b0;
    rc_frame_valid = 1'b0;
    chk("ab_nflag", flag_cnt - f0, 2);
    chk_widths("ab_b", 1100, 1200, 1300, 1400, 1600, 1700);
`else
    chk("fs_nflag", flag_cnt - f0, 1);
    chk("fs_src_end", src_state, 2);
    chk_widths("fs", 1500, 1500, 1500, 1500, 1500, 1500);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_cmd_sched.md
SERVO_CMD_SCHED -- requirements
Module: servo_cmd_sched

Interface
REQ-001 Parameter WORDSIZE, default 15: width of every pulse-width/period word (1 LSB = 1 us).
REQ-002 Parameter MIN_WIDTH, default 900: lower clamp bound, us.
REQ-003 Parameter MAX_WIDTH, default 2100: upper clamp bound, us.
REQ-004 Parameter FAILSAFE_WIDTH, default 1500: width published on all channels in failsafe, us.
REQ-005 Parameter TIMEOUT_US, default 100000: source-loss timeout in pwm_clk ticks.
REQ-006 Port clk, input, 1: system clock, 24 MHz. One clock; reset is asynchronous and active-low.
REQ-007 Port rst_n, input, 1: asynchronous active-low reset.
REQ-008 Port pwm_clk, input, 1: 1 MHz tick, one clk cycle wide.
REQ-009 Port host_wr_valid, input, 1: host write request.
REQ-010 Port host_wr_ch, input, 3: 0..5 = channel 1..6 shadow write; 7 = commit; 6 = ignored (accepted, no effect).
REQ-011 Port host_wr_data, input, WORDSIZE: shadow write data.
REQ-012 Port host_wr_ready, output, 1: write accepted on the edge where valid and ready are both high.
REQ-013 Port rc_frame_valid, input, 1: one-cycle strobe; an RC receiver frame is present on rc_width.
REQ-014 Port rc_width, input, 6*WORDSIZE: channel 1 in LSBs.
REQ-015 Ports pulse_width_ch1..ch6, output, WORDSIZE each: widths fed to the servo PWM generator.
REQ-016 Port data_update_flag, output, 1: one-clk pulse; all six widths are new.
REQ-017 Port src_state, output, 2: 0 = HOST, 1 = RC, 2 = FAILSAFE.

Function
REQ-018 Host timer and RC timer: increment on pwm_clk, saturate at TIMEOUT_US, cleared by an accepted commit and by rc_frame_valid respectively; a source is alive while its timer < TIMEOUT_US.
REQ-019 Source selection every clk: HOST if host alive; else RC if RC alive; else FAILSAFE.
REQ-020 Publish triggers: accepted commit (source HOST after commit); rc_frame_valid while host not alive; each entry into FAILSAFE.
REQ-021 Sequencer FSM IDLE -> CLAMP (6 cycles, channel index 0..5, one channel per cycle into staging registers) -> FLAG (1 cycle) -> IDLE.
REQ-022 In FLAG, all six staging values are copied to pulse_width_ch1..ch6 on one edge, and data_update_flag is high for that cycle only; outputs never change at any other time.
REQ-023 Latency: data_update_flag rises 7 clk edges after the trigger edge.
REQ-024 Clamp: value < MIN_WIDTH -> MIN_WIDTH; value > MAX_WIDTH -> MAX_WIDTH; otherwise unchanged; FAILSAFE_WIDTH is also clamped.
REQ-025 host_wr_ready is low whenever the sequencer is not IDLE or a publish is pending.
REQ-026 rc_frame_valid while busy: snapshot rc_width into a pending buffer (a newer frame overwrites it) and publish after returning to IDLE if the host is still not alive.
REQ-027 Host commit and rc_frame_valid on the same edge in IDLE: host frame publishes; the RC frame only refreshes its timer.
REQ-028 Shadow registers persist across commits; an uncommitted shadow write never reaches the outputs.

Reset
REQ-029 On rst_n low: timers = TIMEOUT_US, shadows and staging = FAILSAFE_WIDTH, pulse_width_ch* = FAILSAFE_WIDTH, data_update_flag = 0, host_wr_ready = 0, src_state = 2, FSM = IDLE, pending cleared.
REQ-030 The first cycle after reset release triggers a FAILSAFE publish; reset asserted mid-sequence aborts the sequence with no flag.

Configuration
REQ-031 With macro SERVO_RC_PASSTHRU_EN defined, the RC source behaves as specified; without it, rc_frame_valid and rc_width are ignored, src_state never equals 1, and host loss goes directly to FAILSAFE.

Structure
REQ-032 Shared package: WORDSIZE, src_state encodings, sequencer state encodings, default MIN/MAX/FAILSAFE widths.
REQ-033 One sub-module, servo_width_clamp, holds the clamp logic and is instantiated once, time-shared over the six channels.

Verification
REQ-034 Reset release, no stimulus -> src_state = 2, all widths 1500, one data_update_flag 7 edges after release.
REQ-035 Host writes ch1 = 500, ch2 = 2500, ch3..6 = 1200, then commit -> widths 900/2100/1200 x4, flag once, src_state = 0, ready low for 8 cycles.
REQ-036 Host silent for 100000 pwm_clk ticks, RC frames with all channels 1600 every 20000 ticks -> src_state goes 0 -> 1, widths 1600, one flag per frame.
REQ-037 RC frame A arrives during a host publish, then frame B before IDLE, host since timed out -> only B published after the host pass completes.
REQ-038 Build without SERVO_RC_PASSTHRU_EN, host times out while RC frames toggle -> src_state goes 0 -> 2, widths 1500, RC frames ignored.
REQ-039 rst_n pulsed low during CLAMP -> no flag from the aborted pass, outputs 1500, post-reset failsafe publish follows.
